// File: rtl/sap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_pkg: opcodes, one-hot T-states and control word for the bus computer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sap_pkg;

  localparam logic [3:0] c_OP_LDA = 4'b0000;
  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_OUT = 4'b1110;
  localparam logic [3:0] c_OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic enPC;
    logic OE_PC;
    logic WE_MAR;
    logic OE_RAM;
    logic WE_IR;
    logic OE_IR;
    logic WE_Acc;
    logic OE_Acc;
    logic WE_Breg;
    logic OE_ALU;
    logic SUB;
    logic WE_OR;
  } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/control_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_rom: decodes (T-state, opcode) into the control word and flags   |
// | the last T-state of the instruction.                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module control_rom
  import sap_pkg::*;
#(
  parameter int OPW       = 4,
  parameter bit SKIP_IDLE = 1'b0
) (
  input  logic [5:0]     t_state,
  input  logic [OPW-1:0] opcode,
  output ctrl_word_t     ctrl,
  output logic           last
);

  logic w_is_lda, w_is_add, w_is_sub, w_is_out, w_is_hlt, w_is_nop;

  assign w_is_lda = (opcode == OPW'(c_OP_LDA));
  assign w_is_add = (opcode == OPW'(c_OP_ADD));
  assign w_is_sub = (opcode == OPW'(c_OP_SUB));
  assign w_is_out = (opcode == OPW'(c_OP_OUT));
  assign w_is_hlt = (opcode == OPW'(c_OP_HLT));
  assign w_is_nop = !(w_is_lda || w_is_add || w_is_sub || w_is_out || w_is_hlt);

  always_comb begin
    ctrl = '0;
    last = 1'b0;
    case (t_state)
      T1: begin
        ctrl.OE_PC  = 1'b1;
        ctrl.WE_MAR = 1'b1;
      end
      T2: ctrl.enPC = 1'b1;
      T3: begin
        ctrl.OE_RAM = 1'b1;
        ctrl.WE_IR  = 1'b1;
      end
      T4: begin
        if (w_is_lda || w_is_add || w_is_sub) begin
          ctrl.OE_IR  = 1'b1;
          ctrl.WE_MAR = 1'b1;
        end else if (w_is_out) begin
          ctrl.OE_Acc = 1'b1;
          ctrl.WE_OR  = 1'b1;
        end
        last = w_is_hlt || (SKIP_IDLE && (w_is_out || w_is_nop));
      end
      T5: begin
        if (w_is_lda) begin
          ctrl.OE_RAM = 1'b1;
          ctrl.WE_Acc = 1'b1;
        end else if (w_is_add || w_is_sub) begin
          ctrl.OE_RAM  = 1'b1;
          ctrl.WE_Breg = 1'b1;
        end
        last = SKIP_IDLE && w_is_lda;
      end
      T6: begin
        if (w_is_add || w_is_sub) begin
          ctrl.OE_ALU = 1'b1;
          ctrl.WE_Acc = 1'b1;
          ctrl.SUB    = w_is_sub;
        end
        // The ring wraps here regardless, so T6 always ends the instruction.
        last = 1'b1;
      end
      default: begin
        ctrl = '0;
        last = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/controller_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | controller_sequencer: T-state ring counter, halt latch and strobe gating |
// | for the 8-bit bus computer.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module controller_sequencer
  import sap_pkg::*;
#(
  parameter int OPW       = 4,
  parameter bit SKIP_IDLE = 1'b0
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  output logic           enPC,
  output logic           OE_PC,
  output logic           WE_MAR,
  output logic           OE_RAM,
  output logic           WE_IR,
  output logic           OE_IR,
  output logic           WE_Acc,
  output logic           OE_Acc,
  output logic           WE_Breg,
  output logic           OE_ALU,
  output logic           SUB,
  output logic           WE_OR,
  output logic           HLT,
  output logic [5:0]     t_state,
  output logic           instr_done
);

  tstate_e    r_state, w_state_nxt;
  logic       r_hlt, w_hlt_nxt;
  ctrl_word_t w_rom, w_cw;
  logic       w_last, w_halt_op, w_quiet;

  control_rom #(
    .OPW      (OPW),
    .SKIP_IDLE(SKIP_IDLE)
  ) u_rom (
    .t_state(r_state),
    .opcode (opcode),
    .ctrl   (w_rom),
    .last   (w_last)
  );

  assign w_halt_op = (r_state == T4) && (opcode == OPW'(c_OP_HLT));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= T1;
      r_hlt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hlt   <= w_hlt_nxt;
    end
  end

  // Halting leaves the ring parked on T4 rather than wrapping to T1.
  always_comb begin
    w_state_nxt = r_state;
    w_hlt_nxt   = r_hlt;
    if (en && !r_hlt) begin
      if (w_halt_op) begin
        w_hlt_nxt = 1'b1;
      end else if (w_last) begin
        w_state_nxt = T1;
      end else begin
        case (r_state)
          T1:      w_state_nxt = T2;
          T2:      w_state_nxt = T3;
          T3:      w_state_nxt = T4;
          T4:      w_state_nxt = T5;
          T5:      w_state_nxt = T6;
          default: w_state_nxt = T1;
        endcase
      end
    end
  end

  assign w_quiet    = RESET || r_hlt;
  assign w_cw       = w_quiet ? '0 : w_rom;
  assign instr_done = !w_quiet && w_last;
  assign HLT        = r_hlt;
  assign t_state    = r_state;

  assign enPC    = w_cw.enPC;
  assign OE_PC   = w_cw.OE_PC;
  assign WE_MAR  = w_cw.WE_MAR;
  assign OE_RAM  = w_cw.OE_RAM;
  assign WE_IR   = w_cw.WE_IR;
  assign OE_IR   = w_cw.OE_IR;
  assign WE_Acc  = w_cw.WE_Acc;
  assign OE_Acc  = w_cw.OE_Acc;
  assign WE_Breg = w_cw.WE_Breg;
  assign OE_ALU  = w_cw.OE_ALU;
  assign SUB     = w_cw.SUB;
  assign WE_OR   = w_cw.WE_OR;

endmodule
`default_nettype wire

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit for the 8-bit bus computer.
- Takes the opcode from the instruction register and steps a six-state T-counter through fetch and execute.
- Drives the per-module OE/WE/enable strobes that the register, ALU, memory and output modules respond to on the shared 8-bit bus.
- Replaces manual select/go strobing with automatic sequencing.

Parameters:
- OPW, 4, opcode width (IR upper nibble).
- SKIP_IDLE, 0: 1 = instructions with no work in later T-states return to T1 early; 0 = every instruction takes 6 cycles.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-high reset.
- en  input  1  sequencer advance enable; low holds the T-state and the control word.
- opcode  input  OPW  IR opcode; valid from T4 onward.
- enPC  output  1  PC increment.
- OE_PC  output  1  PC drives bus.
- WE_MAR  output  1  MAR loads from bus.
- OE_RAM  output  1  RAM drives bus.
- WE_IR  output  1  IR loads from bus.
- OE_IR  output  1  IR operand nibble drives bus.
- WE_Acc  output  1  accumulator loads.
- OE_Acc  output  1  accumulator drives bus.
- WE_Breg  output  1  B register loads.
- OE_ALU  output  1  ALU result drives bus.
- SUB  output  1  ALU subtract select.
- WE_OR  output  1  output register loads.
- HLT  output  1  halted flag; also gates the PC.
- t_state  output  6  one-hot T-state, T1 = bit 0.
- instr_done  output  1  high in the final T-state of each instruction.

Behaviour:
- Reset (asynchronous): t_state = 6'b000001, HLT = 0. While RESET is high, all control outputs and instr_done are 0.
- After reset releases: T1 outputs asserted.
- T-state register advances only on posedge CLK with en = 1 and HLT = 0. Sequence T1→T2→…→T6→T1.
- Control word and instr_done are combinational from (t_state, opcode, HLT). They are stable for the whole cycle, so consumers load on the next posedge.
- Opcodes: LDA = 0000, ADD = 0001, SUB = 0010, OUT = 1110, HLT = 1111; all others NOP.
- T1: OE_PC, WE_MAR.
- T2: enPC.
- T3: OE_RAM, WE_IR.
- T4:
  - LDA/ADD/SUB: OE_IR, WE_MAR.
  - OUT: OE_Acc, WE_OR.
  - HLT: no strobes; HLT latches to 1 at the posedge ending T4.
  - NOP: none.
- T5:
  - LDA: OE_RAM, WE_Acc.
  - ADD/SUB: OE_RAM, WE_Breg.
  - others: none.
- T6:
  - ADD: OE_ALU, WE_Acc.
  - SUB: SUB, OE_ALU, WE_Acc.
  - others: none.
- SUB output is 0 in every state except SUB-opcode T6.
- SKIP_IDLE = 1: last state is T5 for LDA, T4 for OUT/NOP, T6 for ADD/SUB. The next state after the last state is T1.
- instr_done:
  - asserted in the last state of the instruction;
  - asserted in T4 for HLT;
  - never asserted while HLT = 1.
- Halt:
  - once HLT = 1, t_state freezes at T4 and all control strobes are 0;
  - the latch is cleared only by RESET;
  - en has no effect while halted.
- en low mid-instruction: state and control word are held. Strobes stay asserted, so a held WE re-loads the same data; this is harmless by design.
- Bus rule: at most one of OE_PC, OE_RAM, OE_IR, OE_Acc, OE_ALU is high in any cycle. A WE strobe is never asserted without exactly one OE, except T2 (enPC only).
- Reset mid-instruction: immediate return to T1 state. Partial instruction is abandoned.
- Opcode changing in T1–T3 does not affect outputs; decode uses opcode only in T4–T6.

Decomposition:
- Package sap_pkg:
  - opcode localparams (LDA, ADD, SUB, OUT, HLT);
  - one-hot T-state constants T1..T6;
  - packed struct ctrl_word_t {enPC, OE_PC, WE_MAR, OE_RAM, WE_IR, OE_IR, WE_Acc, OE_Acc, WE_Breg, OE_ALU, SUB, WE_OR}.
- Sub-module control_rom: pure combinational (t_state, opcode) → ctrl_word_t plus last-state flag.
- The top holds the ring counter and the halt latch, and applies gating.

Test Plan:
- Reset then en = 1, opcode = 0000, SKIP_IDLE = 0 → cycles 1–6 show:
  - T1 {OE_PC, WE_MAR}, T2 {enPC}, T3 {OE_RAM, WE_IR}, T4 {OE_IR, WE_MAR}, T5 {OE_RAM, WE_Acc}, T6 none;
  - instr_done in cycle 6; t_state returns to 000001.
- opcode = 0010 → T6 asserts SUB, OE_ALU, WE_Acc; the preceding T5 asserts WE_Breg; SUB is 0 in all other cycles.
- opcode = 1111 → at T4 instr_done = 1. Next posedge: HLT = 1, t_state stays 001000 for 20 cycles with en = 1, all strobes 0. RESET pulse → HLT = 0, t_state = 000001.
- SKIP_IDLE = 1, opcode = 1110 → T4 asserts OE_Acc, WE_OR, instr_done; next cycle is T1. Full instruction takes 4 cycles.
- en dropped during T5 of ADD for 3 cycles → t_state and {OE_RAM, WE_Breg} held; resumes to T6 when en returns.
- RESET asserted asynchronously mid-T5 (between clock edges) → all strobes 0 immediately; after release t_state = 000001. Random opcode/en run: the one-OE bus assertion never fires.
